// File: rtl/gather_vc_allocator.sv
// Output-VC allocator for a gather router port.
// Tracks busy/owner/round-robin state for each output VC and grants every free
// VC to one requesting input port per cycle. Grants are combinational so the
// input controller can steer its crossbar in the same cycle.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req           per-port one-hot VC request, slice [p*VN +: VN] is port p
//   tail_fire     per-port pulse when that port's tail flit transfers
//   grant         port p won a VC this cycle (combinational)
//   sel_vc        one-hot VC won by port p, slice [p*VN +: VN] (combinational)
//   vc_busy       registered busy flag per output VC
//   req_err       registered sticky illegal request/release flag
module gather_vc_allocator #(
  parameter int unsigned PN = 5,
  parameter int unsigned VN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PN*VN-1:0] req,
  input  logic [PN-1:0]    tail_fire,
  output logic [PN-1:0]    grant,
  output logic [PN*VN-1:0] sel_vc,
  output logic [VN-1:0]    vc_busy,
  output logic             req_err
);

  localparam int unsigned PW = (PN > 1) ? $clog2(PN) : 1;

  logic [VN-1:0] busy;
  logic [PW-1:0] owner  [VN];
  logic [PW-1:0] rr_ptr [VN];

  logic [PN-1:0] owns;
  logic [PN-1:0] multi;
  logic [PN-1:0] any_req;
  logic [VN-1:0] eff    [PN];
  logic [PN-1:0] cand   [VN];
  logic [PN-1:0] win    [VN];
  logic [PN-1:0] won;
  logic [VN-1:0] release_v;
  logic          err_c;

  // Isolate the lowest set bit of a request slice.
  function automatic logic [VN-1:0] lowest_bit(input logic [VN-1:0] x);
    lowest_bit = x & (~x + VN'(1));
  endfunction

  // First candidate at or after ptr, wrapping modulo PN.
  function automatic logic [PN-1:0] rr_pick(input logic [PN-1:0] c,
                                            input logic [PW-1:0] ptr);
    logic          found;
    logic [PW-1:0] idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < PN; i++) begin
      idx = PW'((32'(ptr) + i) % PN);
      if (!found && c[idx]) begin
        rr_pick[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

  // Which ports currently hold a VC.
  always_comb begin
    owns = '0;
    for (int v = 0; v < VN; v++) begin
      if (busy[v]) owns[owner[v]] = 1'b1;
    end
  end

  // Normalise requests and mask ports that already own a VC.
  always_comb begin
    multi   = '0;
    any_req = '0;
    for (int p = 0; p < PN; p++) begin
      eff[p]     = owns[p] ? '0 : lowest_bit(req[p*VN +: VN]);
      multi[p]   = $countones(req[p*VN +: VN]) > 1;
      any_req[p] = |req[p*VN +: VN];
    end
  end

  // Independent round-robin arbitration per free VC.
  always_comb begin
    for (int v = 0; v < VN; v++) begin
      cand[v] = '0;
      for (int p = 0; p < PN; p++) cand[v][p] = eff[p][v];
      win[v] = busy[v] ? '0 : rr_pick(cand[v], rr_ptr[v]);
    end
  end

  // Fold per-VC winners into per-port grant/select; blanked during reset.
  always_comb begin
    logic [VN-1:0] port_sel;
    grant  = '0;
    sel_vc = '0;
    won    = '0;
    for (int p = 0; p < PN; p++) begin
      port_sel = '0;
      for (int v = 0; v < VN; v++) port_sel[v] = win[v][p];
      won[p] = |port_sel;
      if (!rst) begin
        grant[p]           = |port_sel;
        sel_vc[p*VN +: VN] = port_sel;
      end
    end
  end

  // Releases by owners, and illegal-event detection.
  always_comb begin
    for (int v = 0; v < VN; v++) release_v[v] = busy[v] && tail_fire[owner[v]];
    // A tail in the grant cycle is a single-flit packet, not a stray release.
    err_c = (|multi) || (|(owns & any_req)) || (|(tail_fire & ~owns & ~won));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      req_err <= 1'b0;
      for (int v = 0; v < VN; v++) begin
        owner[v]  <= '0;
        rr_ptr[v] <= '0;
      end
    end else begin
      req_err <= req_err | err_c;
      for (int v = 0; v < VN; v++) begin
        if (release_v[v]) busy[v] <= 1'b0;
        for (int p = 0; p < PN; p++) begin
          if (win[v][p]) begin
            owner[v]  <= PW'(p);
            rr_ptr[v] <= PW'((p + 1) % PN);
            // Same-cycle tail frees the VC before it ever goes busy.
            busy[v]   <= !tail_fire[p];
          end
        end
      end
    end
  end

  assign vc_busy = busy;

endmodule

// File: tb/tb_gather_vc_allocator.sv
// Bench for gather_vc_allocator: directed scenarios with literal expectations,
// plus a behavioural reference model compared against the DUT every cycle.
module tb_gather_vc_allocator;

  localparam int PN = 5;
  localparam int VN = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [PN*VN-1:0] req;
  logic [PN-1:0]    tail_fire;
  logic [PN-1:0]    grant;
  logic [PN*VN-1:0] sel_vc;
  logic [VN-1:0]    vc_busy;
  logic             req_err;

  gather_vc_allocator #(.PN(PN), .VN(VN)) dut (
    .clk(clk), .rst(rst), .req(req), .tail_fire(tail_fire),
    .grant(grant), .sel_vc(sel_vc), .vc_busy(vc_busy), .req_err(req_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model state.
  bit m_busy  [VN];
  int m_owner [VN];
  int m_rr    [VN];
  bit m_err;
  bit started = 0;

  // Outputs implied by the allocation rules for the given inputs and model state.
  task automatic model_eval(input logic [PN*VN-1:0] r, input logic [PN-1:0] t,
                            output logic [PN-1:0] g, output logic [PN*VN-1:0] s,
                            output bit e);
    int want [PN];
    bit owns [PN];
    logic [VN-1:0] sl;
    int best, bestd, d;
    g = '0; s = '0; e = 0;
    for (int p = 0; p < PN; p++) begin
      owns[p] = 0;
      for (int v = 0; v < VN; v++) if (m_busy[v] && m_owner[v] == p) owns[p] = 1;
    end
    for (int p = 0; p < PN; p++) begin
      sl = r[p*VN +: VN];
      want[p] = -1;
      for (int v = VN - 1; v >= 0; v--) if (sl[v]) want[p] = v;
      if ($countones(sl) > 1) e = 1;
      if (owns[p] && sl != 0) begin
        e = 1;
        want[p] = -1;
      end
    end
    for (int v = 0; v < VN; v++) begin
      if (!m_busy[v]) begin
        best = -1; bestd = PN;
        for (int p = 0; p < PN; p++) begin
          if (want[p] == v) begin
            d = (p - m_rr[v] + PN) % PN;
            if (d < bestd) begin bestd = d; best = p; end
          end
        end
        if (best >= 0) begin
          g[best] = 1'b1;
          s[best*VN + v] = 1'b1;
        end
      end
    end
    for (int p = 0; p < PN; p++) if (t[p] && !owns[p] && !g[p]) e = 1;
  endtask

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    logic [PN-1:0]    g;
    logic [PN*VN-1:0] s;
    bit               e;
    if (rst) begin
      for (int v = 0; v < VN; v++) begin m_busy[v] = 0; m_owner[v] = 0; m_rr[v] = 0; end
      m_err = 0;
      started = 1;
    end else if (started) begin
      model_eval(req, tail_fire, g, s, e);
      m_err = m_err | e;
      for (int v = 0; v < VN; v++) if (m_busy[v] && tail_fire[m_owner[v]]) m_busy[v] = 0;
      for (int v = 0; v < VN; v++)
        for (int p = 0; p < PN; p++)
          if (s[p*VN + v]) begin
            m_owner[v] = p;
            m_rr[v]    = (p + 1) % PN;
            m_busy[v]  = !tail_fire[p];
          end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [PN-1:0]    g;
    logic [PN*VN-1:0] s;
    logic [VN-1:0]    b;
    bit               e;
    if (started) begin
      model_eval(req, tail_fire, g, s, e);
      if (rst) begin g = '0; s = '0; end
      for (int v = 0; v < VN; v++) b[v] = m_busy[v];
      chk("model_grant", 32'(grant), 32'(g));
      chk("model_sel_vc", 32'(sel_vc), 32'(s));
      chk("model_vc_busy", 32'(vc_busy), 32'(b));
      chk("model_req_err", 32'(req_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [VN-1:0] v);
    req[p*VN +: VN] = v;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PN-1:0] last_g;
    int gi;
    int order [6];
    order = '{0, 1, 3, 0, 1, 3};

    // Reset with a pending request: grants must stay low.
    rst = 1'b1; req = '0; tail_fire = '0;
    set_req(2, 5'b00010);
    #1;
    chk("grant_during_reset", 32'(grant), 32'h0);
    tick(); tick();

    // Single request, zero-latency grant, busy then release.
    rst = 1'b0; #1;
    chk("single_grant", 32'(grant), 32'b00100);
    chk("single_sel", 32'(sel_vc[2*VN +: VN]), 32'b00010);
    chk("single_busy_pre", 32'(vc_busy), 32'h0);
    tick();
    req = '0; tail_fire[2] = 1'b1; #1;
    chk("single_busy", 32'(vc_busy), 32'b00010);
    tick();
    tail_fire = '0; #1;
    chk("single_release", 32'(vc_busy), 32'h0);
    chk("single_no_err", 32'(req_err), 32'h0);
    // rr_ptr[1] is now 3, so port 3 beats port 0.
    set_req(0, 5'b00010); set_req(3, 5'b00010); #1;
    chk("rr_after_port2", 32'(grant), 32'b01000);
    tick();
    req = '0; tail_fire[3] = 1'b1;
    tick();
    tail_fire = '0;

    // Contention on VC0 from ports 0, 1, 3.
    set_req(0, 5'b00001); set_req(1, 5'b00001); set_req(3, 5'b00001);
    last_g = '0; gi = 0;
    for (int c = 0; c < 24 && gi < 6; c++) begin
      tail_fire = last_g; #1;
      if (last_g != 0) begin
        chk("no_grant_in_release", 32'(grant), 32'h0);
        last_g = '0;
      end else if (grant != 0) begin
        chk("grant_order", 32'(grant), 32'(1 << order[gi]));
        gi++;
        last_g = grant;
      end
      tick();
    end
    chk("contention_complete", 32'(gi), 32'd6);
    tail_fire = last_g; req = '0;
    tick();
    tail_fire = '0;

    // Parallel grants on independent VCs.
    set_req(0, 5'b00001); set_req(1, 5'b00100); set_req(4, 5'b10000); #1;
    chk("parallel_grant", 32'(grant), 32'b10011);
    chk("parallel_sel4", 32'(sel_vc[4*VN +: VN]), 32'b10000);
    tick();
    req = '0; #1;
    chk("parallel_busy", 32'(vc_busy), 32'b10101);
    tail_fire = 5'b10011;
    tick();
    tail_fire = '0; #1;
    chk("parallel_release", 32'(vc_busy), 32'h0);

    // Single-flit packet: VC3 never goes busy.
    set_req(3, 5'b01000); tail_fire[3] = 1'b1; #1;
    chk("single_flit_grant", 32'(grant), 32'b01000);
    tick();
    req = '0; tail_fire = '0; set_req(1, 5'b01000); #1;
    chk("single_flit_busy", 32'(vc_busy), 32'h0);
    chk("single_flit_next", 32'(grant), 32'b00010);
    tick();
    req = '0; tail_fire[1] = 1'b1;
    tick();
    tail_fire = '0;

    // Multi-bit request error.
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("err_cleared", 32'(req_err), 32'h0);
    set_req(0, 5'b00110); #1;
    chk("multi_grant", 32'(grant), 32'b00001);
    chk("multi_sel", 32'(sel_vc[0*VN +: VN]), 32'b00010);
    chk("multi_err_pre", 32'(req_err), 32'h0);
    tick();
    req = '0; #1;
    chk("multi_err", 32'(req_err), 32'h1);
    chk("multi_busy", 32'(vc_busy), 32'b00010);
    tail_fire[0] = 1'b1;
    tick();
    tail_fire = '0;

    // Stray tail from a port that owns nothing.
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 5'b00001);
    tick();
    req = '0; tail_fire[2] = 1'b1;
    tick();
    tail_fire = '0; #1;
    chk("stray_err", 32'(req_err), 32'h1);
    chk("stray_busy", 32'(vc_busy), 32'b00001);

    // Mid-packet reset while VC0 and VC1 are busy.
    set_req(1, 5'b00010);
    tick();
    req = '0; #1;
    chk("midpkt_busy", 32'(vc_busy), 32'b00011);
    rst = 1'b1; set_req(2, 5'b00001); #1;
    chk("midpkt_grant_rst", 32'(grant), 32'h0);
    tick();
    rst = 1'b0; #1;
    chk("midpkt_cleared", 32'(vc_busy), 32'h0);
    chk("midpkt_regrant", 32'(grant), 32'b00100);
    chk("midpkt_sel", 32'(sel_vc[2*VN +: VN]), 32'b00001);
    tick();
    req = '0; tail_fire[2] = 1'b1;
    tick();
    tail_fire = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
